// File: rtl/aes128_pkg.sv
// aes128_pkg: shared AES-128 widths, FSM state type, round-key select and GF(2^8) helpers.
package aes128_pkg;
  localparam int AES_BLOCK_W  = 128;
  localparam int AES_NR       = 10;
  localparam int AES_RK_BUS_W = 1408;
  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} state_e;
  function automatic logic [AES_BLOCK_W-1:0] rk_sel(input logic [AES_RK_BUS_W-1:0] bus, input logic [3:0] k);
    return bus[{k, 7'b0} +: AES_BLOCK_W];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, m;
    p = '0;
    x = a;
    m = b;
    for (int i = 0; i < 8; i++) begin
      p = p ^ ((m & 8'h01) != 0 ? x : 8'h00);
      m = m >> 1;
      x = xtime(x);
    end
    return p;
  endfunction
  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, x;
    r = 8'h01;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, x);
      x = gf_mul(x, x);
    end
    return r;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
  endfunction
endpackage

// File: rtl/aes128_inv_round.sv
// aes128_inv_round: one combinational AES inverse round with optional InvMixColumns.
module aes_inv_shift_rows (
  input  logic [127:0] d_i,
  output logic [127:0] q_o
);
  for (genvar c = 0; c < 4; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      assign q_o[127-8*(r+4*((c+r)%4)) -: 8] = d_i[127-8*(r+4*c) -: 8];
    end
  end
endmodule

module aes_inv_sub_bytes
  import aes128_pkg::*;
(
  input  logic [127:0] d_i,
  output logic [127:0] q_o
);
  for (genvar i = 0; i < 16; i++) begin : g_b
    assign q_o[8*i +: 8] = inv_sbox(d_i[8*i +: 8]);
  end
endmodule

module aes_add_round_key (
  input  logic [127:0] d_i,
  input  logic [127:0] k_i,
  output logic [127:0] q_o
);
  assign q_o = d_i ^ k_i;
endmodule

module aes_inv_mix_columns
  import aes128_pkg::*;
(
  input  logic [127:0] d_i,
  output logic [127:0] q_o
);
  for (genvar c = 0; c < 4; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      assign q_o[127-8*(4*c+r) -: 8] = gf_mul(8'h0e, d_i[127-8*(4*c+r) -: 8])
                                      ^ gf_mul(8'h0b, d_i[127-8*(4*c+(r+1)%4) -: 8])
                                      ^ gf_mul(8'h0d, d_i[127-8*(4*c+(r+2)%4) -: 8])
                                      ^ gf_mul(8'h09, d_i[127-8*(4*c+(r+3)%4) -: 8]);
    end
  end
endmodule

module aes128_inv_round
  import aes128_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state_in,
  input  logic [AES_BLOCK_W-1:0] round_key,
  input  logic                   mix,
  output logic [AES_BLOCK_W-1:0] state_out
);
  logic [AES_BLOCK_W-1:0] sr, sb, ak, mc;
  aes_inv_shift_rows  u_sr (.d_i(state_in), .q_o(sr));
  aes_inv_sub_bytes   u_sb (.d_i(sr), .q_o(sb));
  aes_add_round_key   u_ak (.d_i(sb), .k_i(round_key), .q_o(ak));
  aes_inv_mix_columns u_mc (.d_i(ak), .q_o(mc));
  assign state_out = mix ? mc : ak;
endmodule

// File: rtl/aes128_decrypt_ctrl.sv
// aes128_decrypt_ctrl: iterative AES-128 decrypt sequencer over one shared inverse-round datapath.
module aes128_decrypt_ctrl
  import aes128_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [AES_BLOCK_W-1:0]  ciphertext,
  input  logic [AES_RK_BUS_W-1:0] round_keys,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [AES_BLOCK_W-1:0]  plaintext,
  output logic                    busy
);
  if (NUM_ROUNDS != AES_NR) begin : g_bad_nr
    $error("aes128_decrypt_ctrl: NUM_ROUNDS must be 10");
  end
  state_e state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic [AES_BLOCK_W-1:0] st_q, st_d, round_out;
  aes128_inv_round u_round (
    .state_in (st_q),
    .round_key(rk_sel(round_keys, rnd_q)),
    .mix      (rnd_q != 4'd0),
    .state_out(round_out)
  );
  assign in_ready  = state_q == ST_IDLE;
  assign busy      = state_q != ST_IDLE;
  assign out_valid = state_q == ST_DONE;
  assign plaintext = out_valid ? st_q : '0;
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) begin
        st_d    = ciphertext ^ rk_sel(round_keys, 4'(AES_NR));
        rnd_d   = 4'(AES_NR - 1);
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        st_d    = round_out;
        rnd_d   = rnd_q != 4'd0 ? rnd_q - 4'd1 : rnd_q;
        state_d = rnd_q != 4'd0 ? ST_ROUND : ST_DONE;
      end
      ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
    end
  end
endmodule

// File: tb/tb_aes128_decrypt_ctrl.sv
// tb_aes128_decrypt_ctrl: scoreboard bench driving the decrypt sequencer against a forward-cipher AES model.
module tb_aes128_decrypt_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, busy;
  logic [127:0] ciphertext = '0, plaintext;
  logic [1407:0] round_keys = '0;
  int n_tests = 0, n_fail = 0, cyc = 0, last_acc = 0, or_mode = 0;
  typedef struct {logic [127:0] pt; int acc;} exp_t;
  exp_t sb[$];
  logic [7:0] sbox [256];

  aes128_decrypt_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .round_keys(round_keys), .out_valid(out_valid),
    .out_ready(out_ready), .plaintext(plaintext), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The key source contract: round keys are held for the whole life of a block.
  assert property (@(posedge clk) disable iff (!rst_n) (busy && $past(busy)) |-> $stable(round_keys))
    else $error("FAIL rk_stable: round_keys changed while busy");

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
    return (x << s) | (x >> (8 - s));
  endfunction

  // Forward S-box from the generator-3 walk of GF(2^8) and its inverse walk.
  task automatic init_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      q = q ^ (q[7] ? 8'h09 : 8'h00);
      sbox[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rcon;
    logic [1407:0] bus;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]] ^ rcon, sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) bus[k*128 +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return bus;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] bus);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ bus[127-8*i -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rd < 10) begin
        for (int i = 0; i < 16; i++) t[i] = s[i];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[4*c+r] = xt(t[4*c+r]) ^ xt(t[4*c+(r+1)%4]) ^ t[4*c+(r+1)%4]
                     ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ bus[rd*128+127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // out_ready policy: 0 always ready, 1 stalled, 2 random stalls.
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = (or_mode == 0) ? 1'b1 : (or_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  initial begin
    logic ov_prev, hold_prev;
    logic [127:0] pt_prev;
    exp_t e;
    ov_prev = 1'b0;
    hold_prev = 1'b0;
    pt_prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ov_prev = 1'b0;
        hold_prev = 1'b0;
      end else begin
        check("ready_vs_busy", {127'b0, in_ready}, {127'b0, !busy});
        if (!out_valid) check("pt_masked", plaintext, '0);
        if (hold_prev) begin
          check("hold_valid", {127'b0, out_valid}, 128'd1);
          check("hold_pt", plaintext, pt_prev);
        end
        if (out_valid && !ov_prev && sb.size() != 0) check("latency", 128'(cyc - sb[0].acc), 128'd10);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got %h expected none", plaintext);
          end else begin
            e = sb.pop_front();
            check("plaintext", plaintext, e.pt);
          end
        end
        ov_prev = out_valid;
        hold_prev = out_valid && !out_ready;
        pt_prev = plaintext;
      end
    end
  end

  task automatic send(input logic [127:0] ct, input logic [1407:0] rk, input logic [127:0] pt, input bit hold);
    int n;
    n = 0;
    if (!in_valid)
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
    ciphertext = ct;
    round_keys = rk;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles expected high", n);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    sb.push_back('{pt, cyc});
    last_acc = cyc;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d results outstanding expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] key_c1, ct_c1, pt_c1, pt2, ct2, k, p;
    logic [1407:0] rk_c1, rk;
    int a1, n;
    key_c1 = 128'h000102030405060708090a0b0c0d0e0f;
    ct_c1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    pt_c1  = 128'h00112233445566778899aabbccddeeff;
    init_sbox();
    rk_c1 = expand(key_c1);
    check("model_rk10", rk_c1[1407:1280], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("model_encrypt", encrypt(pt_c1, rk_c1), ct_c1);
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    ct2 = encrypt(pt2, rk_c1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {127'b0, in_ready}, 128'd1);
    check("rst_out_valid", {127'b0, out_valid}, 128'd0);
    check("rst_busy", {127'b0, busy}, 128'd0);
    check("rst_plaintext", plaintext, '0);
    rst_n = 1'b1;
    send(ct_c1, rk_c1, pt_c1, 1'b0);
    drain();
    or_mode = 1;
    send(ct_c1, rk_c1, pt_c1, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_seen", {127'b0, out_valid}, 128'd1);
    repeat (20) @(negedge clk);
    check("bp_valid", {127'b0, out_valid}, 128'd1);
    check("bp_pt", plaintext, pt_c1);
    check("bp_in_ready", {127'b0, in_ready}, 128'd0);
    or_mode = 0;
    drain();
    send(ct_c1, rk_c1, pt_c1, 1'b1);
    a1 = last_acc;
    send(ct2, rk_c1, pt2, 1'b0);
    check("b2b_gap", 128'(last_acc - a1), 128'd12);
    drain();
    send(ct_c1, rk_c1, pt_c1, 1'b0);
    repeat (3) @(negedge clk);
    ciphertext = ct2;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    repeat (15) @(negedge clk);
    send(ct_c1, rk_c1, pt_c1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_rst_in_ready", {127'b0, in_ready}, 128'd1);
    check("mid_rst_out_valid", {127'b0, out_valid}, 128'd0);
    check("mid_rst_busy", {127'b0, busy}, 128'd0);
    check("mid_rst_plaintext", plaintext, '0);
    send(ct_c1, rk_c1, pt_c1, 1'b0);
    drain();
    or_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      rk = expand(k);
      send(encrypt(p, rk), rk, p, 1'b0);
    end
    drain();
    or_mode = 0;
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
